// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: load opcode, FSM
// state encoding and pipeline stage indices.
package hazard_ctrl_pkg;

  localparam logic [6:0] INST_TYPE_L = 7'b0000011;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MC_HOLD  = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module hazard_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: jump flush, multi-cycle EX hold and load-use
// stall sequencing, plus stall/flush performance counters.
//
//   state       | meaning
//   ST_IDLE     | no stall in progress, load-use detection armed
//   ST_LU_STALL | load-use stall continuing, lu_cnt cycles remain
//   ST_MC_HOLD  | multi-cycle EX op was holding the pipe last cycle
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 7,
  parameter int NUM_STAGES = 5,
  parameter int EX_STAGE   = STAGE_EX,
  parameter int LU_CYCLES  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_flag_i,
  input  logic [ADDR_W-1:0]     jump_addr_i,
  input  logic                  mc_hold_i,
  input  logic [OPCODE_W-1:0]   ex_opcode_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic                  cnt_clr_i,
  output logic [NUM_STAGES-1:0] hold_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  pc_jump_flag_o,
  output logic [ADDR_W-1:0]     pc_jump_addr_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam logic [NUM_STAGES-1:0] UPTO_EX_MASK = NUM_STAGES'((1 << (EX_STAGE + 1)) - 1);
  localparam logic [NUM_STAGES-1:0] BEFORE_EX_MASK = NUM_STAGES'((1 << EX_STAGE) - 1);
  localparam logic [NUM_STAGES-1:0] EX_BIT   = NUM_STAGES'(1) << EX_STAGE;
  localparam logic [NUM_STAGES-1:0] POST_EX_BIT = NUM_STAGES'(1) << (EX_STAGE + 1);
  localparam logic [3:0]            LU_INIT  = 4'(LU_CYCLES - 1);

  hz_state_e             state_q, state_d;
  logic [3:0]            lu_cnt_q, lu_cnt_d;
  logic                  lu_hit;
  logic [NUM_STAGES-1:0] hold_c, flush_c;
  logic                  pc_flag_c;

  assign lu_hit = (ex_opcode_i == OPCODE_W'(INST_TYPE_L)) && (ex_rd_addr_i != '0) &&
                  ((id_rs1_used_i && (ex_rd_addr_i == id_rs1_addr_i)) ||
                   (id_rs2_used_i && (ex_rd_addr_i == id_rs2_addr_i)));

  always_comb begin
    state_d   = state_q;
    lu_cnt_d  = lu_cnt_q;
    hold_c    = '0;
    flush_c   = '0;
    pc_flag_c = 1'b0;
    if (jump_flag_i) begin
      flush_c   = UPTO_EX_MASK;
      pc_flag_c = 1'b1;
      state_d   = ST_IDLE;
      lu_cnt_d  = 4'd0;
    end else if (mc_hold_i) begin
      hold_c   = UPTO_EX_MASK;
      flush_c  = POST_EX_BIT;
      state_d  = ST_MC_HOLD;
      lu_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lu_hit) begin
            hold_c  = BEFORE_EX_MASK;
            flush_c = EX_BIT;
            if (LU_CYCLES > 1) begin
              state_d  = ST_LU_STALL;
              lu_cnt_d = LU_INIT;
            end
          end
        end
        ST_LU_STALL: begin
          hold_c   = BEFORE_EX_MASK;
          flush_c  = EX_BIT;
          lu_cnt_d = lu_cnt_q - 4'd1;
          if (lu_cnt_q == 4'd1) state_d = ST_IDLE;
        end
        // Drop cycle of a multi-cycle op: detection stays off until back in IDLE.
        ST_MC_HOLD: state_d = ST_IDLE;
        default: begin
          state_d  = ST_IDLE;
          lu_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lu_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign hold_o         = rst ? '0 : hold_c;
  assign flush_o        = rst ? '0 : flush_c;
  assign pc_jump_flag_o = rst ? 1'b0 : pc_flag_c;
  assign pc_jump_addr_o = pc_jump_flag_o ? jump_addr_i : '0;

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr_i),
    .inc_i (|hold_o),
    .cnt_o (stall_cnt_o)
  );

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr_i),
    .inc_i (jump_flag_i),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LU_CYCLES=1, LU_CYCLES=3, CNT_W=4)
// on shared stimulus, checked by a behavioural model plus directed sequences.
module tb_hazard_ctrl;

  typedef struct {
    logic        jump;
    logic [31:0] addr;
    logic        mc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        clr;
    logic        rst;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [4:0]  hold;
    logic [4:0]  flush;
    logic        pcf;
    logic [31:0] pca;
  } vec_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk;
  logic        rst, jump, mc, u1, u2, clr;
  logic [31:0] jaddr;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;

  logic [4:0]  hold [3];
  logic [4:0]  flush [3];
  logic        pcf [3];
  logic [31:0] pca [3];
  logic [15:0] sc [3];
  logic [15:0] fc [3];
  logic [3:0]  sc_c4, fc_c4;

  assign sc[2] = {12'h000, sc_c4};
  assign fc[2] = {12'h000, fc_c4};

  int n_checks = 0;
  int n_errors = 0;

  int lu_c [3] = '{1, 3, 3};
  int cmax [3] = '{65535, 65535, 15};
  int m_left [3];
  bit m_mc [3];
  int m_sc [3];
  int m_fc [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl #(.LU_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .jump_flag_i(jump), .jump_addr_i(jaddr), .mc_hold_i(mc),
    .ex_opcode_i(op), .ex_rd_addr_i(rd), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .cnt_clr_i(clr),
    .hold_o(hold[0]), .flush_o(flush[0]), .pc_jump_flag_o(pcf[0]), .pc_jump_addr_o(pca[0]),
    .stall_cnt_o(sc[0]), .flush_cnt_o(fc[0]));

  hazard_ctrl #(.LU_CYCLES(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .jump_flag_i(jump), .jump_addr_i(jaddr), .mc_hold_i(mc),
    .ex_opcode_i(op), .ex_rd_addr_i(rd), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .cnt_clr_i(clr),
    .hold_o(hold[1]), .flush_o(flush[1]), .pc_jump_flag_o(pcf[1]), .pc_jump_addr_o(pca[1]),
    .stall_cnt_o(sc[1]), .flush_cnt_o(fc[1]));

  hazard_ctrl #(.LU_CYCLES(3), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .jump_flag_i(jump), .jump_addr_i(jaddr), .mc_hold_i(mc),
    .ex_opcode_i(op), .ex_rd_addr_i(rd), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .cnt_clr_i(clr),
    .hold_o(hold[2]), .flush_o(flush[2]), .pc_jump_flag_o(pcf[2]), .pc_jump_addr_o(pca[2]),
    .stall_cnt_o(sc_c4), .flush_cnt_o(fc_c4));

  function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    end
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '{jump: 1'b0, addr: 32'h0, mc: 1'b0, op: OP_ALU, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
          u1: 1'b0, u2: 1'b0, clr: 1'b0, rst: 1'b0};
    return s;
  endfunction

  function automatic stim_t hit_s();
    stim_t s;
    s = idle_s();
    s.op = OP_LOAD; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
    return s;
  endfunction

  // Model: stall cycles remaining, whether last cycle was a multi-cycle hold,
  // and the two counters, all derived from the priority rules.
  task automatic model_check();
    bit          hit;
    int          act;
    logic [4:0]  eh, ef;
    logic        epf;
    logic [31:0] ea;
    hit = (op == OP_LOAD) && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    for (int k = 0; k < 3; k++) begin
      eh = 0; ef = 0; epf = 0; ea = 0; act = 0;
      if (rst) begin
        m_left[k] = 0; m_mc[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else if (jump) act = 1;
      else if (mc) act = 2;
      else if (m_left[k] > 0) act = 3;
      else if (!m_mc[k] && hit) act = 4;
      case (act)
        1: begin ef = 5'b00111; epf = 1'b1; ea = jaddr; end
        2: begin eh = 5'b00111; ef = 5'b01000; end
        3, 4: begin eh = 5'b00011; ef = 5'b00100; end
        default: ;
      endcase
      chk("m_hold", k, 32'(hold[k]), 32'(eh));
      chk("m_flush", k, 32'(flush[k]), 32'(ef));
      chk("m_pcf", k, 32'(pcf[k]), 32'(epf));
      chk("m_pca", k, pca[k], ea);
      chk("m_stall_cnt", k, 32'(sc[k]), 32'(m_sc[k]));
      chk("m_flush_cnt", k, 32'(fc[k]), 32'(m_fc[k]));
      if (!rst) begin
        if (clr) begin
          m_sc[k] = 0; m_fc[k] = 0;
        end else begin
          if (eh != 0 && m_sc[k] < cmax[k]) m_sc[k]++;
          if (jump && m_fc[k] < cmax[k]) m_fc[k]++;
        end
        m_mc[k] = (act == 2);
        if (act == 3)      m_left[k]--;
        else if (act == 4) m_left[k] = lu_c[k] - 1;
        else               m_left[k] = 0;
      end
    end
  endtask

  task automatic step(input stim_t s);
    @(negedge clk);
    jump = s.jump; jaddr = s.addr; mc = s.mc; op = s.op; rd = s.rd;
    rs1 = s.rs1; rs2 = s.rs2; u1 = s.u1; u2 = s.u2; clr = s.clr; rst = s.rst;
    #1;
    model_check();
  endtask

  task automatic reset_all();
    stim_t s;
    s = idle_s();
    s.rst = 1'b1;
    step(s);
    step(idle_s());
  endtask

  vec_t vt [11];

  initial begin
    stim_t s;
    rst = 1'b1; jump = 0; jaddr = 0; mc = 0; op = OP_ALU; rd = 0; rs1 = 0; rs2 = 0;
    u1 = 0; u2 = 0; clr = 0;

    // Directed vectors, checked against dut_a (LU_CYCLES=1), applied in order.
    for (int i = 0; i < 11; i++) begin
      vt[i].s = idle_s(); vt[i].hold = 5'b0; vt[i].flush = 5'b0; vt[i].pcf = 1'b0; vt[i].pca = 32'h0;
    end
    vt[0].s.rst = 1'b1;
    vt[1].s = hit_s(); vt[1].hold = 5'b00011; vt[1].flush = 5'b00100;
    vt[2].s = hit_s(); vt[2].s.rd = 5'd0; vt[2].s.rs1 = 5'd0;
    vt[3].s.op = OP_LOAD; vt[3].s.rd = 5'd7; vt[3].s.rs2 = 5'd7; vt[3].s.u2 = 1'b0;
    vt[4].s.op = OP_LOAD; vt[4].s.rd = 5'd7; vt[4].s.rs2 = 5'd7; vt[4].s.u2 = 1'b1;
    vt[4].hold = 5'b00011; vt[4].flush = 5'b00100;
    vt[5].s = hit_s(); vt[5].s.op = OP_ALU;
    vt[6].s = hit_s(); vt[6].s.mc = 1'b1; vt[6].s.jump = 1'b1; vt[6].s.addr = 32'h1234;
    vt[6].flush = 5'b00111; vt[6].pcf = 1'b1; vt[6].pca = 32'h1234;
    vt[7].s = hit_s(); vt[7].s.mc = 1'b1; vt[7].hold = 5'b00111; vt[7].flush = 5'b01000;
    vt[8].s = hit_s();
    vt[9].s = hit_s(); vt[9].hold = 5'b00011; vt[9].flush = 5'b00100;
    vt[10].s.addr = 32'hdead_beef;

    for (int i = 0; i < 11; i++) begin
      step(vt[i].s);
      chk($sformatf("vec%0d_hold", i), 0, 32'(hold[0]), 32'(vt[i].hold));
      chk($sformatf("vec%0d_flush", i), 0, 32'(flush[0]), 32'(vt[i].flush));
      chk($sformatf("vec%0d_pcf", i), 0, 32'(pcf[0]), 32'(vt[i].pcf));
      chk($sformatf("vec%0d_pca", i), 0, pca[0], vt[i].pca);
    end

    // Single hit: 1-cycle stall on dut_a, 3-cycle stall on dut_b.
    reset_all();
    step(hit_s());
    chk("lu1_hold_c1", 0, 32'(hold[0]), 32'h03);
    chk("lu3_hold_c1", 1, 32'(hold[1]), 32'h03);
    step(idle_s());
    chk("lu1_hold_c2", 0, 32'(hold[0]), 32'h00);
    chk("lu3_hold_c2", 1, 32'(hold[1]), 32'h03);
    chk("lu3_flush_c2", 1, 32'(flush[1]), 32'h04);
    step(idle_s());
    chk("lu3_hold_c3", 1, 32'(hold[1]), 32'h03);
    step(idle_s());
    chk("lu3_hold_c4", 1, 32'(hold[1]), 32'h00);
    chk("lu1_stall_cnt", 0, 32'(sc[0]), 32'd1);
    chk("lu3_stall_cnt", 1, 32'(sc[1]), 32'd3);

    // Jump during second stall cycle.
    reset_all();
    step(hit_s());
    s = idle_s(); s.jump = 1'b1; s.addr = 32'h80;
    step(s);
    chk("jmp_flush", 1, 32'(flush[1]), 32'h07);
    chk("jmp_hold", 1, 32'(hold[1]), 32'h00);
    chk("jmp_addr", 1, pca[1], 32'h80);
    step(idle_s());
    chk("jmp_after_hold", 1, 32'(hold[1]), 32'h00);
    chk("jmp_flush_cnt", 1, 32'(fc[1]), 32'd1);

    // Multi-cycle hold for 4 cycles.
    reset_all();
    s = idle_s(); s.mc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(s);
      chk("mc_hold", 0, 32'(hold[0]), 32'h07);
      chk("mc_flush", 0, 32'(flush[0]), 32'h08);
    end
    step(idle_s());
    chk("mc_done_hold", 0, 32'(hold[0]), 32'h00);
    chk("mc_stall_cnt", 0, 32'(sc[0]), 32'd4);

    // Saturation at CNT_W=4, then clear.
    reset_all();
    for (int i = 0; i < 20; i++) step(s);
    step(idle_s());
    chk("sat_cnt4", 2, 32'(sc[2]), 32'd15);
    chk("sat_cnt16", 0, 32'(sc[0]), 32'd20);
    s = idle_s(); s.clr = 1'b1;
    step(s);
    step(idle_s());
    chk("clr_cnt4", 2, 32'(sc[2]), 32'd0);

    // Reset in the middle of a load-use stall.
    step(hit_s());
    s = hit_s(); s.rst = 1'b1;
    step(s);
    chk("rst_hold", 1, 32'(hold[1]), 32'h00);
    chk("rst_flush", 1, 32'(flush[1]), 32'h00);
    chk("rst_cnt", 1, 32'(sc[1]), 32'd0);
    step(idle_s());
    chk("post_rst_hold", 1, 32'(hold[1]), 32'h00);

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      s.jump = ($urandom_range(0, 9) == 0);
      s.addr = $urandom();
      s.mc   = ($urandom_range(0, 6) == 0);
      s.op   = ($urandom_range(0, 1) != 0) ? OP_LOAD : OP_ALU;
      s.rd   = 5'($urandom_range(0, 3));
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.clr  = ($urandom_range(0, 40) == 0);
      s.rst  = ($urandom_range(0, 150) == 0);
      step(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
